// File: rtl/llc_cache_model.sv
// Last-level cache controller model: 16-way set-associative, write-allocate,
// MESI coherence, tree pseudo-LRU replacement. One trace command per cycle;
// each command updates the arrays, the statistics and the registered outputs
// at the clock edge that samples it.
//
// Handshake: a command is consumed at every rising clk where cmd_valid = 1;
// there is no back-pressure. Each output reflects the command of the
// previous edge for exactly one cycle and returns to idle (bus_op 0,
// victim_wb 0, l1_msg 0, snoop_resp NOHIT) after a cycle without a command.
module llc_cache_model #(
  parameter int ADDR_BITS = 32,
  parameter int CMDSIZE   = 4,
  parameter int WAYS      = 16,
  parameter int SETS      = 16384
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [CMDSIZE-1:0]   command,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [31:0]          mode,
  output logic [31:0]          reads,
  output logic [31:0]          writes,
  output logic [31:0]          cache_hits,
  output logic [31:0]          cache_misses,
  output logic [2:0]           bus_op,
  output logic                 victim_wb,
  output logic [1:0]           snoop_resp,
  output logic [2:0]           l1_msg
);

  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int NODE_BITS   = WAY_BITS + 1;

  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;

  localparam logic [2:0] BUS_NONE  = 3'd0;
  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INV   = 3'd3;
  localparam logic [2:0] BUS_RWIM  = 3'd4;

  localparam logic [1:0] SNP_HIT   = 2'd0;
  localparam logic [1:0] SNP_HITM  = 2'd1;
  localparam logic [1:0] SNP_NOHIT = 2'd2;

  localparam logic [2:0] L1_NONE     = 3'd0;
  localparam logic [2:0] L1_GETLINE  = 3'd1;
  localparam logic [2:0] L1_SENDLINE = 3'd2;
  localparam logic [2:0] L1_INVLINE  = 3'd3;
  localparam logic [2:0] L1_EVICT    = 3'd4;

  // Line storage. Tags need no reset: a line in I never matches.
  mesi_e                mesi_q [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_q  [SETS][WAYS];
  logic [WAYS-2:0]      plru_q [SETS];

  logic [31:0] reads_q, reads_d, writes_q, writes_d;
  logic [31:0] hits_q, hits_d, misses_q, misses_d;
  logic [2:0]  bus_op_q, bus_op_d, l1_msg_q, l1_msg_d;
  logic        victim_wb_q, victim_wb_d;
  logic [1:0]  snoop_resp_q, snoop_resp_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag_in;
  mesi_e                 set_mesi   [WAYS];
  mesi_e                 set_mesi_d [WAYS];
  logic [WAYS-2:0]       set_plru, plru_d;
  logic                  hit, inv_found, fill_en, clear_all;
  logic [WAY_BITS-1:0]   hit_way, inv_way, victim_way;

  // Offset bits below the snoop-result bit and the display mode have no
  // effect on this model's state or outputs.
  logic unused_bits;
  assign unused_bits = ^{mode, address[OFFSET_BITS-1:2], address[0]};

  assign idx    = address[OFFSET_BITS +: INDEX_BITS];
  assign tag_in = address[ADDR_BITS-1 -: TAG_BITS];

  // Tree is stored heap-style: node n has children 2n+1 (left, lower ways)
  // and 2n+2 (right); leaves WAYS-1 .. 2*WAYS-2 map to ways 0 .. WAYS-1.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [2*WAYS-2:0]    full;
    logic [NODE_BITS-1:0] node;
    logic [NODE_BITS-1:0] leaf;
    full = '0;
    full[WAYS-2:0] = tree;
    node = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      node = (node << 1) + NODE_BITS'(1) + NODE_BITS'(full[node]);
    end
    leaf = node - NODE_BITS'(WAYS - 1);
    return leaf[WAY_BITS-1:0];
  endfunction

  // Point every node on the path to 'way' at the opposite subtree.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WAY_BITS-1:0] way);
    logic [2*WAYS-2:0]    full;
    logic [NODE_BITS-1:0] node;
    logic [WAY_BITS-1:0]  w;
    logic                 go_right;
    full = '0;
    full[WAYS-2:0] = tree;
    node = '0;
    w = way;
    for (int l = 0; l < WAY_BITS; l++) begin
      go_right   = w[WAY_BITS-1];
      full[node] = ~go_right;
      node       = (node << 1) + NODE_BITS'(1) + NODE_BITS'(go_right);
      w          = w << 1;
    end
    return full[WAYS-2:0];
  endfunction

  // Tag lookup and victim selection within the addressed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    set_plru  = plru_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      set_mesi[w] = mesi_q[idx][w];
    end
    for (int w = 0; w < WAYS; w++) begin
      if (set_mesi[w] != ST_I && tag_q[idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    // Descending scan so the lowest invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_mesi[w] == ST_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    victim_way = inv_found ? inv_way : plru_victim(set_plru);
  end

  // Command decode: next line states, PLRU, counters and output values.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      set_mesi_d[w] = set_mesi[w];
    end
    plru_d       = set_plru;
    fill_en      = 1'b0;
    clear_all    = 1'b0;
    reads_d      = reads_q;
    writes_d     = writes_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    bus_op_d     = BUS_NONE;
    victim_wb_d  = 1'b0;
    snoop_resp_d = SNP_NOHIT;
    l1_msg_d     = L1_NONE;
    if (cmd_valid) begin
      case (command)
        CMDSIZE'(0), CMDSIZE'(2): begin
          reads_d  = reads_q + 32'd1;
          l1_msg_d = L1_SENDLINE;
          if (hit) begin
            hits_d = hits_q + 32'd1;
            plru_d = plru_touch(set_plru, hit_way);
          end else begin
            misses_d = misses_q + 32'd1;
            bus_op_d = BUS_READ;
            fill_en  = 1'b1;
            // Other caches answer NOHIT when address[1] is set.
            set_mesi_d[victim_way] = address[1] ? ST_E : ST_S;
            plru_d = plru_touch(set_plru, victim_way);
            if (set_mesi[victim_way] != ST_I) begin
              l1_msg_d    = L1_EVICT;
              victim_wb_d = (set_mesi[victim_way] == ST_M);
            end
          end
        end
        CMDSIZE'(1): begin
          writes_d = writes_q + 32'd1;
          if (hit) begin
            hits_d = hits_q + 32'd1;
            if (set_mesi[hit_way] == ST_S) bus_op_d = BUS_INV;
            set_mesi_d[hit_way] = ST_M;
            plru_d = plru_touch(set_plru, hit_way);
          end else begin
            misses_d = misses_q + 32'd1;
            bus_op_d = BUS_RWIM;
            fill_en  = 1'b1;
            set_mesi_d[victim_way] = ST_M;
            plru_d = plru_touch(set_plru, victim_way);
            if (set_mesi[victim_way] != ST_I) begin
              l1_msg_d    = L1_EVICT;
              victim_wb_d = (set_mesi[victim_way] == ST_M);
            end
          end
        end
        CMDSIZE'(3): begin
          if (hit && set_mesi[hit_way] == ST_S) begin
            set_mesi_d[hit_way] = ST_I;
            l1_msg_d = L1_INVLINE;
          end
        end
        CMDSIZE'(4): begin
          if (hit) begin
            if (set_mesi[hit_way] == ST_M) begin
              snoop_resp_d = SNP_HITM;
              l1_msg_d     = L1_GETLINE;
              bus_op_d     = BUS_WRITE;
            end else begin
              snoop_resp_d = SNP_HIT;
            end
            set_mesi_d[hit_way] = ST_S;
          end
        end
        CMDSIZE'(6): begin
          if (hit) begin
            if (set_mesi[hit_way] == ST_M) begin
              snoop_resp_d = SNP_HITM;
              bus_op_d     = BUS_WRITE;
            end
            l1_msg_d = L1_INVLINE;
            set_mesi_d[hit_way] = ST_I;
          end
        end
        CMDSIZE'(8): begin
          clear_all = 1'b1;
          reads_d   = '0;
          writes_d  = '0;
          hits_d    = '0;
          misses_d  = '0;
        end
        default: begin
          // Snooped write, print and unknown codes leave everything as is.
        end
      endcase
    end
  end

  // Line state and PLRU arrays; clear-all empties the whole cache in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) mesi_q[s][w] <= ST_I;
        plru_q[s] <= '0;
      end
    end else if (clear_all) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) mesi_q[s][w] <= ST_I;
        plru_q[s] <= '0;
      end
    end else if (cmd_valid) begin
      for (int w = 0; w < WAYS; w++) mesi_q[idx][w] <= set_mesi_d[w];
      plru_q[idx] <= plru_d;
    end
  end

  // Tag written only when a miss allocates a way.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[idx][victim_way] <= tag_in;
  end

  // Statistics counters and registered per-command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q      <= '0;
      writes_q     <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      bus_op_q     <= BUS_NONE;
      victim_wb_q  <= 1'b0;
      snoop_resp_q <= SNP_NOHIT;
      l1_msg_q     <= L1_NONE;
    end else begin
      reads_q      <= reads_d;
      writes_q     <= writes_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      bus_op_q     <= bus_op_d;
      victim_wb_q  <= victim_wb_d;
      snoop_resp_q <= snoop_resp_d;
      l1_msg_q     <= l1_msg_d;
    end
  end

  assign reads        = reads_q;
  assign writes       = writes_q;
  assign cache_hits   = hits_q;
  assign cache_misses = misses_q;
  assign bus_op       = bus_op_q;
  assign victim_wb    = victim_wb_q;
  assign snoop_resp   = snoop_resp_q;
  assign l1_msg       = l1_msg_q;

endmodule

// File: tb/tb_llc_cache_model.sv
// Testbench for llc_cache_model: scenario tasks drive commands and push the
// expected {bus_op, victim_wb, snoop_resp, l1_msg} onto exp_q; an output
// monitor pops and compares one entry per consumed command.
module tb_llc_cache_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [3:0]  command;
  logic [31:0] address;
  logic [31:0] mode;
  logic [31:0] reads, writes, cache_hits, cache_misses;
  logic [2:0]  bus_op, l1_msg;
  logic        victim_wb;
  logic [1:0]  snoop_resp;

  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  int checks = 0;
  int errors = 0;

  llc_cache_model dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .command(command),
    .address(address), .mode(mode), .reads(reads), .writes(writes),
    .cache_hits(cache_hits), .cache_misses(cache_misses), .bus_op(bus_op),
    .victim_wb(victim_wb), .snoop_resp(snoop_resp), .l1_msg(l1_msg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [8:0] pk(input logic [2:0] b, input logic wb,
                                    input logic [1:0] sr, input logic [2:0] l1);
    return {b, wb, sr, l1};
  endfunction

  localparam logic [8:0] IDLE = 9'b000_0_10_000;

  // Scoreboard: one expected output word per command consumed
  always @(posedge clk) begin
    if (rst_n && cmd_valid) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output %h arrived with no expected entry",
                 {bus_op, victim_wb, snoop_resp, l1_msg});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus_op, victim_wb, snoop_resp, l1_msg} !== mon_exp) begin
          errors++;
          $display("FAIL cmd_out @%0t: got bus=%0d wb=%0d snp=%0d l1=%0d expected bus=%0d wb=%0d snp=%0d l1=%0d",
                   $time, bus_op, victim_wb, snoop_resp, l1_msg,
                   mon_exp[8:6], mon_exp[5], mon_exp[4:3], mon_exp[2:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [8:0] e);
    @(negedge clk);
    cmd_valid = 1'b1;
    command   = c;
    address   = a;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    cmd_valid = 1'b0;
    command   = '0;
    address   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; command = '0; address = '0; mode = 32'd1;
    #12;
    checks++;
    if ({bus_op, victim_wb, snoop_resp, l1_msg} !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {bus_op, victim_wb, snoop_resp, l1_msg}, IDLE);
    end
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== 128'd0) begin
      errors++;
      $display("FAIL reset_counters: got r=%0d w=%0d h=%0d m=%0d expected all 0", reads, writes, cache_hits, cache_misses);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    logic [31:0] a;
    a = 32'h10019D96;
    drive(4'd8, 32'h0, IDLE);
    drive(4'd0, a, pk(3'd1, 1'b0, 2'd2, 3'd2));  // miss, NOHIT -> E
    drive(4'd0, a, pk(3'd0, 1'b0, 2'd2, 3'd2));  // hit
    drive(4'd1, a, pk(3'd0, 1'b0, 2'd2, 3'd0));  // E -> M silently
    drive(4'd5, a, pk(3'd0, 1'b0, 2'd2, 3'd0));  // snooped write: no change
    drive(4'd4, a, pk(3'd2, 1'b0, 2'd1, 3'd1));  // still M: HITM
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd2, 32'd1, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL read_counters: got r=%0d w=%0d h=%0d m=%0d expected r=2 w=1 h=2 m=1", reads, writes, cache_hits, cache_misses);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus_op, victim_wb, snoop_resp, l1_msg} !== IDLE) begin
      errors++;
      $display("FAIL idle_return: got %h expected %h", {bus_op, victim_wb, snoop_resp, l1_msg}, IDLE);
    end
  endtask

  task automatic test_write_shared();
    logic [31:0] b;
    b = 32'h20000080;
    drive(4'd8, 32'h0, IDLE);
    drive(4'd0, b, pk(3'd1, 1'b0, 2'd2, 3'd2));  // miss, HIT -> S
    drive(4'd1, b, pk(3'd3, 1'b0, 2'd2, 3'd0));  // S -> M, INVALIDATE
    drive(4'd4, b, pk(3'd2, 1'b0, 2'd1, 3'd1));  // M -> S, HITM
    drive(4'd4, b, pk(3'd0, 1'b0, 2'd0, 3'd0));  // S: HIT
    drive(4'd3, b, pk(3'd0, 1'b0, 2'd2, 3'd3));  // S -> I
    drive(4'd0, b, pk(3'd1, 1'b0, 2'd2, 3'd2));  // misses again
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd2, 32'd1, 32'd1, 32'd2}) begin
      errors++;
      $display("FAIL shared_counters: got r=%0d w=%0d h=%0d m=%0d expected r=2 w=1 h=1 m=2", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_rwim();
    logic [31:0] c, d;
    c = 32'h30000142;
    d = 32'h30000241;
    drive(4'd8, 32'h0, IDLE);
    drive(4'd0, c, pk(3'd1, 1'b0, 2'd2, 3'd2));  // fill E
    drive(4'd6, c, pk(3'd0, 1'b0, 2'd2, 3'd3));  // E -> I
    drive(4'd0, c, pk(3'd1, 1'b0, 2'd2, 3'd2));  // gone: miss
    drive(4'd1, d, pk(3'd4, 1'b0, 2'd2, 3'd0));  // write miss: RWIM, M
    drive(4'd6, d, pk(3'd2, 1'b0, 2'd1, 3'd3));  // M -> I, HITM
    drive(4'd4, d, pk(3'd0, 1'b0, 2'd2, 3'd0));  // I: NOHIT
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd2, 32'd1, 32'd0, 32'd3}) begin
      errors++;
      $display("FAIL rwim_counters: got r=%0d w=%0d h=%0d m=%0d expected r=2 w=1 h=0 m=3", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_plru_default();
    drive(4'd8, 32'h0, IDLE);
    for (int t = 0; t < 16; t++) drive(4'd0, {12'(t), 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd2));
    drive(4'd0, {12'd16, 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd4));  // evicts way 0 (tag 0)
    drive(4'd0, {12'd1, 20'h00002}, pk(3'd0, 1'b0, 2'd2, 3'd2));   // tag 1 kept
    drive(4'd0, {12'd0, 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd4));   // tag 0 gone
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd19, 32'd0, 32'd1, 32'd18}) begin
      errors++;
      $display("FAIL plru_default_counters: got r=%0d w=%0d h=%0d m=%0d expected r=19 w=0 h=1 m=18", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_plru_touch();
    drive(4'd8, 32'h0, IDLE);
    for (int t = 0; t < 16; t++) drive(4'd0, {12'(t), 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd2));
    drive(4'd0, {12'd0, 20'h00002}, pk(3'd0, 1'b0, 2'd2, 3'd2));   // touch way 0
    drive(4'd0, {12'd16, 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd4));  // evicts way 8
    drive(4'd0, {12'd0, 20'h00002}, pk(3'd0, 1'b0, 2'd2, 3'd2));   // tag 0 still hits
    drive(4'd0, {12'd8, 20'h00002}, pk(3'd1, 1'b0, 2'd2, 3'd4));   // tag 8 gone
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd20, 32'd0, 32'd2, 32'd18}) begin
      errors++;
      $display("FAIL plru_touch_counters: got r=%0d w=%0d h=%0d m=%0d expected r=20 w=0 h=2 m=18", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_victim_wb();
    drive(4'd8, 32'h0, IDLE);
    drive(4'd1, {12'd0, 20'h00042}, pk(3'd4, 1'b0, 2'd2, 3'd0));   // way 0 in M
    for (int t = 1; t < 16; t++) drive(4'd0, {12'(t), 20'h00042}, pk(3'd1, 1'b0, 2'd2, 3'd2));
    drive(4'd0, {12'd16, 20'h00042}, pk(3'd1, 1'b1, 2'd2, 3'd4));  // M victim written back
    drive(4'd0, {12'd0, 20'h00042}, pk(3'd1, 1'b0, 2'd2, 3'd4));   // clean victim now
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd17, 32'd1, 32'd0, 32'd18}) begin
      errors++;
      $display("FAIL victim_counters: got r=%0d w=%0d h=%0d m=%0d expected r=17 w=1 h=0 m=18", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f;
    f = 32'h00F00081;
    drive(4'd8, 32'h0, IDLE);
    drive(4'd1, f, pk(3'd4, 1'b0, 2'd2, 3'd0));   // write miss
    drive(4'd0, f, pk(3'd0, 1'b0, 2'd2, 3'd2));   // sees the fill: hit
    drive(4'd7, f, IDLE);
    drive(4'd12, f, IDLE);
    drive(4'd9, f, IDLE);
    drive(4'd4, f, pk(3'd2, 1'b0, 2'd1, 3'd1));   // still M
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL b2b_counters: got r=%0d w=%0d h=%0d m=%0d expected r=1 w=1 h=1 m=1", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_clear();
    logic [31:0] e;
    e = 32'h00ABC002;
    drive(4'd0, e, pk(3'd1, 1'b0, 2'd2, 3'd2));
    for (int i = 0; i < 9; i++) drive(4'd0, e, pk(3'd0, 1'b0, 2'd2, 3'd2));
    drive(4'd8, 32'h0, IDLE);
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== 128'd0) begin
      errors++;
      $display("FAIL clear_counters: got r=%0d w=%0d h=%0d m=%0d expected all 0", reads, writes, cache_hits, cache_misses);
    end
    drive(4'd0, e, pk(3'd1, 1'b0, 2'd2, 3'd2));   // line was invalidated
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL clear_after: got r=%0d w=%0d h=%0d m=%0d expected r=1 w=0 h=0 m=1", reads, writes, cache_hits, cache_misses);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] y;
    y = 32'h0DEAD100 + 32'($urandom_range(0, 15) << 6);
    drive(4'd0, y, pk(3'd1, 1'b0, 2'd2, 3'd2));   // fill S
    drive(4'd1, y, pk(3'd3, 1'b0, 2'd2, 3'd0));   // INVALIDATE still on outputs
    settle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_op, victim_wb, snoop_resp, l1_msg} !== IDLE) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected %h", {bus_op, victim_wb, snoop_resp, l1_msg}, IDLE);
    end
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== 128'd0) begin
      errors++;
      $display("FAIL async_reset_counters: got r=%0d w=%0d h=%0d m=%0d expected all 0", reads, writes, cache_hits, cache_misses);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd0, y, pk(3'd1, 1'b0, 2'd2, 3'd2));   // line lost by reset
    settle();
    checks++;
    if ({reads, writes, cache_hits, cache_misses} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL reset_after: got r=%0d w=%0d h=%0d m=%0d expected r=1 w=0 h=0 m=1", reads, writes, cache_hits, cache_misses);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_read();
    test_write_shared();
    test_rwim();
    test_plru_default();
    test_plru_touch();
    test_victim_wb();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
